// File: rtl/mem_req_axi_pkg.sv
// Shared types and AXI field constants for the BRAM-style request to AXI4 master bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_req_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_8B     = 3'b011;

endpackage

// File: rtl/mem_req_axi_if.sv
// AXI4 bus bundle with Master/Slave views.
// Latency: n/a (wiring only).
// Backpressure: standard AXI valid/ready on every channel.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [5:0]                aw_atop;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0]     w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/mem_req_axi_master.sv
// Single-outstanding AXI4 master: BRAM-style req/we/addr port to single-beat AXI reads/writes.
// Latency: grant is combinational; completion pulse (rvalid_o) no earlier than 3 cycles after grant.
// Backpressure: gnt_o held off while busy and in the completion cycle; MEM_REQ_ERR_STICKY_EN adds sticky error capture.
module mem_req_axi_master
    import mem_req_axi_pkg::*;
#(
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_USER_WIDTH = 1,
    parameter int unsigned AXI_ID         = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    input  logic [7:0]                we_i,
    input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
    input  logic [63:0]               wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [63:0]               rdata_o,
    output logic                      err_o,
    output logic                      busy_o,
`ifdef MEM_REQ_ERR_STICKY_EN
    input  logic                      err_clr_i,
    output logic                      err_sticky_o,
    output logic [AXI_ADDR_WIDTH-1:0] err_addr_o,
`endif
    AXI_BUS.Master                    master
);

    if (AXI_DATA_WIDTH != 64) begin : g_bad_data_width
        $error("mem_req_axi_master: AXI_DATA_WIDTH must be 64");
    end

    state_e                    state_q, state_d;
    logic [1:0]                done_q, done_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                we_q;
    logic [63:0]               wdata_q;
    logic [63:0]               rdata_q;
    logic                      rvalid_q;
    logic                      err_q;

    logic grant;
    logic aw_vld, w_vld, aw_hs, w_hs;
    logic b_done, r_done;

    // Completion cycle blocks the grant so a new request never overlaps rvalid_o.
    assign grant  = (state_q == ST_IDLE) && req_i && !rvalid_q && !rst_i;
    assign aw_vld = (state_q == ST_WR) && !done_q[0];
    assign w_vld  = (state_q == ST_WR) && !done_q[1];
    assign aw_hs  = aw_vld && master.aw_ready;
    assign w_hs   = w_vld && master.w_ready;
    assign b_done = (state_q == ST_WR_RESP) && master.b_valid;
    assign r_done = (state_q == ST_RD_DATA) && master.r_valid;

    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                done_d = 2'b00;
                if (grant) begin
                    state_d = (we_i != 8'h00) ? ST_WR : ST_RD_ADDR;
                end
            end
            ST_WR: begin
                done_d = done_q | {w_hs, aw_hs};
                if (&done_d) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: if (master.b_valid)  state_d = ST_IDLE;
            ST_RD_ADDR: if (master.ar_ready) state_d = ST_RD_DATA;
            ST_RD_DATA: if (master.r_valid)  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            done_q   <= 2'b00;
            addr_q   <= '0;
            we_q     <= 8'h00;
            wdata_q  <= 64'h0;
            rdata_q  <= 64'h0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            rvalid_q <= b_done || r_done;
            if (grant) begin
                addr_q  <= {addr_i[AXI_ADDR_WIDTH-1:3], 3'b000};
                we_q    <= we_i;
                wdata_q <= wdata_i;
            end
            if (b_done) begin
                err_q   <= master.b_resp[1];
                rdata_q <= 64'h0;
            end else if (r_done) begin
                err_q   <= master.r_resp[1];
                rdata_q <= master.r_data;
            end
        end
    end

`ifdef MEM_REQ_ERR_STICKY_EN
    logic                      err_sticky_q;
    logic [AXI_ADDR_WIDTH-1:0] err_addr_q;
    logic                      err_set;

    assign err_set = (b_done && master.b_resp[1]) || (r_done && master.r_resp[1]);

    // Set beats clear; the first error's address is kept until a clear arrives.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_sticky_q <= 1'b0;
            err_addr_q   <= '0;
        end else if (err_set) begin
            err_sticky_q <= 1'b1;
            if (!err_sticky_q || err_clr_i) begin
                err_addr_q <= addr_q;
            end
        end else if (err_clr_i) begin
            err_sticky_q <= 1'b0;
        end
    end

    assign err_sticky_o = err_sticky_q;
    assign err_addr_o   = err_addr_q;
`endif

    assign gnt_o    = grant;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;
    assign busy_o   = (state_q != ST_IDLE);

    assign master.aw_id     = AXI_ID_WIDTH'(AXI_ID);
    assign master.aw_addr   = addr_q;
    assign master.aw_len    = 8'd0;
    assign master.aw_size   = SIZE_8B;
    assign master.aw_burst  = BURST_INCR;
    assign master.aw_lock   = 1'b0;
    assign master.aw_cache  = 4'd0;
    assign master.aw_prot   = 3'd0;
    assign master.aw_qos    = 4'd0;
    assign master.aw_region = 4'd0;
    assign master.aw_atop   = 6'd0;
    assign master.aw_user   = '0;
    assign master.aw_valid  = aw_vld;

    assign master.w_data    = wdata_q;
    assign master.w_strb    = we_q;
    assign master.w_last    = 1'b1;
    assign master.w_user    = '0;
    assign master.w_valid   = w_vld;

    assign master.b_ready   = (state_q == ST_WR_RESP);

    assign master.ar_id     = AXI_ID_WIDTH'(AXI_ID);
    assign master.ar_addr   = addr_q;
    assign master.ar_len    = 8'd0;
    assign master.ar_size   = SIZE_8B;
    assign master.ar_burst  = BURST_INCR;
    assign master.ar_lock   = 1'b0;
    assign master.ar_cache  = 4'd0;
    assign master.ar_prot   = 3'd0;
    assign master.ar_qos    = 4'd0;
    assign master.ar_region = 4'd0;
    assign master.ar_user   = '0;
    assign master.ar_valid  = (state_q == ST_RD_ADDR);

    assign master.r_ready   = (state_q == ST_RD_DATA);

    logic unused_sig;
    assign unused_sig = ^{addr_i[2:0], master.b_id, master.b_resp[0], master.b_user,
                          master.r_id, master.r_resp[0], master.r_last, master.r_user};

endmodule

// File: tb/tb_mem_req_axi_master.sv
// Randomized bench for mem_req_axi_master: AXI slave model with random stalls plus a byte-level memory reference.
// Build with MEM_REQ_ERR_STICKY_EN to include the sticky-error checks.
module tb_mem_req_axi_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic [7:0]  we_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic        gnt_o, rvalid_o, err_o, busy_o;
    logic [63:0] rdata_o;
`ifdef MEM_REQ_ERR_STICKY_EN
    logic        err_clr_i;
    logic        err_sticky_o;
    logic [63:0] err_addr_o;
`endif

    AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1)) axi ();

    mem_req_axi_master dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .err_o(err_o), .busy_o(busy_o),
`ifdef MEM_REQ_ERR_STICKY_EN
        .err_clr_i(err_clr_i), .err_sticky_o(err_sticky_o), .err_addr_o(err_addr_o),
`endif
        .master(axi)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference state and slave-side state
    logic [63:0] ref_mem   [logic [63:0]];
    logic [63:0] slave_mem [logic [63:0]];
    bit          ref_sticky = 0;
    logic [63:0] ref_eaddr  = 64'h0;

    int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    bit inject_err = 0;
    logic [63:0] exp_addr = 0, exp_wdata = 0;
    logic [7:0]  exp_we = 0;
    int n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, n_r = 0, n_rv = 0;
    bit txn_open = 0;
    int last_rv = -10;

    function automatic logic [63:0] init_val(input logic [63:0] k);
        return {k[31:0] ^ 32'hA5A5_5A5A, ~k[31:0]};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] be);
        logic [63:0] v = old;
        for (int i = 0; i < 8; i++) if (be[i]) v[8*i +: 8] = d[8*i +: 8];
        return v;
    endfunction

    function automatic logic [63:0] slave_rd(input logic [63:0] k);
        if (slave_mem.exists(k)) return slave_mem[k];
        return init_val(k);
    endfunction

    function automatic logic [63:0] ref_rd(input logic [63:0] k);
        if (ref_mem.exists(k)) return ref_mem[k];
        return init_val(k);
    endfunction

    // AXI slave + protocol monitor, acting 2 time units after each falling edge
    initial begin
        bit aw_act = 0, w_act = 0, ar_act = 0, aw_done = 0, w_done = 0, ar_done = 0;
        bit b_fire = 0, r_fire = 0, aw_prev = 0, w_prev = 0, ar_prev = 0;
        int aw_c = 0, w_c = 0, ar_c = 0, b_c = 0, r_c = 0;
        logic [63:0] aw_hold = 0, w_hold = 0, ar_hold = 0, pend_addr = 0, pend_data = 0, rd_addr = 0;
        logic [7:0]  pend_strb = 0;
        axi.aw_ready = 0; axi.w_ready = 0; axi.ar_ready = 0;
        axi.b_valid = 0; axi.b_resp = 0; axi.b_id = 0; axi.b_user = 0;
        axi.r_valid = 0; axi.r_resp = 0; axi.r_id = 0; axi.r_user = 0; axi.r_last = 0; axi.r_data = 0;
        forever begin
            @(negedge clk_i); #2;
            if (rst_i) begin
                aw_act = 0; w_act = 0; ar_act = 0; aw_done = 0; w_done = 0; ar_done = 0;
                b_fire = 0; r_fire = 0; aw_prev = 0; w_prev = 0; ar_prev = 0;
                axi.aw_ready = 0; axi.w_ready = 0; axi.ar_ready = 0; axi.b_valid = 0; axi.r_valid = 0;
            end else begin
                if (rvalid_o) n_rv++;
                check_eq("gnt_in_rvalid_cycle", 64'(gnt_o & rvalid_o), 0);
                if (txn_open) check_eq("busy_while_outstanding", 64'(busy_o), 1);
                if (b_fire) begin axi.b_valid = 0; b_fire = 0; end
                if (r_fire) begin axi.r_valid = 0; r_fire = 0; end
                if (aw_done && w_done) begin
                    if (b_c == 0) begin
                        axi.b_valid = 1;
                        axi.b_resp  = inject_err ? 2'b10 : 2'b00;
                        if (!inject_err) slave_mem[pend_addr >> 3] = merge(slave_rd(pend_addr >> 3), pend_data, pend_strb);
                        aw_done = 0; w_done = 0;
                    end else b_c--;
                end
                if (axi.b_valid && axi.b_ready) begin b_fire = 1; n_b++; end
                if (ar_done) begin
                    if (r_c == 0) begin
                        axi.r_valid = 1;
                        axi.r_data  = slave_rd(rd_addr >> 3);
                        axi.r_resp  = inject_err ? 2'b10 : 2'b00;
                        axi.r_last  = 1;
                        ar_done = 0;
                    end else r_c--;
                end
                if (axi.r_valid && axi.r_ready) begin r_fire = 1; n_r++; end
                if (axi.aw_valid) begin
                    if (aw_prev) check_eq("aw_addr_stable", axi.aw_addr, aw_hold);
                    if (!aw_act) begin aw_act = 1; aw_c = aw_dly; end
                    if (aw_c == 0) begin
                        axi.aw_ready = 1; n_aw++; aw_act = 0; aw_prev = 0; aw_done = 1;
                        pend_addr = axi.aw_addr; b_c = b_dly;
                        check_eq("aw_addr", axi.aw_addr, exp_addr);
                        check_eq("aw_len_size_burst", {axi.aw_len, axi.aw_size, axi.aw_burst}, {8'd0, 3'd3, 2'd1});
                    end else begin
                        axi.aw_ready = 0; aw_c--; aw_prev = 1; aw_hold = axi.aw_addr;
                    end
                end else begin axi.aw_ready = 0; aw_prev = 0; end
                if (axi.w_valid) begin
                    if (w_prev) check_eq("w_data_stable", axi.w_data, w_hold);
                    if (!w_act) begin w_act = 1; w_c = w_dly; end
                    if (w_c == 0) begin
                        axi.w_ready = 1; n_w++; w_act = 0; w_prev = 0; w_done = 1;
                        pend_data = axi.w_data; pend_strb = axi.w_strb; b_c = b_dly;
                        check_eq("w_data", axi.w_data, exp_wdata);
                        check_eq("w_strb_last", {axi.w_strb, axi.w_last}, {exp_we, 1'b1});
                    end else begin
                        axi.w_ready = 0; w_c--; w_prev = 1; w_hold = axi.w_data;
                    end
                end else begin axi.w_ready = 0; w_prev = 0; end
                if (axi.ar_valid) begin
                    if (ar_prev) check_eq("ar_addr_stable", axi.ar_addr, ar_hold);
                    if (!ar_act) begin ar_act = 1; ar_c = ar_dly; end
                    if (ar_c == 0) begin
                        axi.ar_ready = 1; n_ar++; ar_act = 0; ar_prev = 0; ar_done = 1;
                        rd_addr = axi.ar_addr; r_c = r_dly;
                        check_eq("ar_addr", axi.ar_addr, exp_addr);
                        check_eq("ar_len_size_burst", {axi.ar_len, axi.ar_size, axi.ar_burst}, {8'd0, 3'd3, 2'd1});
                    end else begin
                        axi.ar_ready = 0; ar_c--; ar_prev = 1; ar_hold = axi.ar_addr;
                    end
                end else begin axi.ar_ready = 0; ar_prev = 0; end
            end
        end
    end

    // One request through the port; chain=1 continues straight from the previous completion cycle.
    task automatic do_req(input logic [7:0] we, input logic [63:0] addr, input logic [63:0] data,
                          input bit err, input bit chain, input bit hold_after, output int lat);
        int g = -1;
        bit found = 0;
        int s_aw = n_aw, s_w = n_w, s_ar = n_ar, s_b = n_b, s_r = n_r, s_rv = n_rv;
        logic [63:0] al = {addr[63:3], 3'b000};
        logic [63:0] exp_rd;
        lat = -1;
        exp_addr = al; exp_we = we; exp_wdata = data; inject_err = err;
        exp_rd = (we == 8'h00) ? ref_rd(al >> 3) : 64'h0;
        if (we != 8'h00 && !err) ref_mem[al >> 3] = merge(ref_rd(al >> 3), data, we);
        if (!chain) @(negedge clk_i);
        req_i = 1; we_i = we; addr_i = addr; wdata_i = data;
        for (int t = 0; t < 200; t++) begin
            #1;
            if (gnt_o) begin g = cyc; break; end
            @(negedge clk_i);
        end
        if (g < 0) begin
            check_eq("grant_timeout", 0, 1);
            req_i = 0;
            return;
        end
        if (chain) check_eq("b2b_grant_after_rvalid", 64'(g > last_rv), 1);
        @(posedge clk_i); #1;
        txn_open = 1;
        if (!hold_after) req_i = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk_i); #1;
            if (rvalid_o) begin found = 1; break; end
        end
        txn_open = 0;
        if (!found) begin
            check_eq("completion_timeout", 0, 1);
            return;
        end
        lat = cyc - g;
        last_rv = cyc;
        check_eq("rdata", rdata_o, exp_rd);
        check_eq("err", 64'(err_o), 64'(err));
`ifdef MEM_REQ_ERR_STICKY_EN
        if (err) begin
            if (!ref_sticky || err_clr_i) ref_eaddr = al;
            ref_sticky = 1;
        end
        check_eq("err_sticky", 64'(err_sticky_o), 64'(ref_sticky));
        if (ref_sticky) check_eq("err_addr", err_addr_o, ref_eaddr);
        err_clr_i = 0;
`endif
        #2;
        check_eq("aw_beats", 64'(n_aw - s_aw), (we != 0) ? 64'd1 : 64'd0);
        check_eq("w_beats",  64'(n_w - s_w),   (we != 0) ? 64'd1 : 64'd0);
        check_eq("b_beats",  64'(n_b - s_b),   (we != 0) ? 64'd1 : 64'd0);
        check_eq("ar_beats", 64'(n_ar - s_ar), (we == 0) ? 64'd1 : 64'd0);
        check_eq("r_beats",  64'(n_r - s_r),   (we == 0) ? 64'd1 : 64'd0);
        check_eq("rvalid_pulses", 64'(n_rv - s_rv), 1);
        if (!chain && !hold_after) begin
            @(negedge clk_i); #1;
            check_eq("rvalid_single_cycle", 64'(rvalid_o), 0);
        end
    endtask

    task automatic set_dly(input int a, input int w, input int ar, input int b, input int r);
        aw_dly = a; w_dly = w; ar_dly = ar; b_dly = b; r_dly = r;
    endtask

    initial begin
        int lat;
        bit prev_hold;
        rst_i = 1; req_i = 0; we_i = 0; addr_i = 0; wdata_i = 0;
`ifdef MEM_REQ_ERR_STICKY_EN
        err_clr_i = 0;
`endif
        repeat (3) @(negedge clk_i);
        #1;
        check_eq("rst_outputs", {gnt_o, rvalid_o, err_o, busy_o}, 0);
        check_eq("rst_rdata", rdata_o, 0);
        check_eq("rst_axi_handshake", {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready}, 0);
        @(negedge clk_i); #4; rst_i = 0;

        // Directed write and read at minimum latency / with AR stall
        set_dly(0, 0, 0, 0, 0);
        do_req(8'hFF, 64'h4000_0008, 64'hDEAD_BEEF_0123_4567, 0, 0, 0, lat);
        check_eq("wr_min_latency", 64'(lat), 3);
        do_req(8'h00, 64'h4000_0008, 64'h0, 0, 0, 0, lat);
        check_eq("rd_min_latency", 64'(lat), 3);
        check_eq("rd_back_written", rdata_o, 64'hDEAD_BEEF_0123_4567);
        ref_mem[64'h4000_0008 >> 3] = 64'h1122_3344_5566_7788;
        slave_mem[64'h4000_0008 >> 3] = 64'h1122_3344_5566_7788;
        set_dly(0, 0, 5, 0, 0);
        do_req(8'h00, 64'h4000_000F, 64'h0, 0, 0, 0, lat);
        check_eq("rd_stall_latency", 64'(lat), 8);

        // AW / W ordering variants
        set_dly(4, 0, 0, 0, 0);
        do_req(8'h0F, 64'h4000_0010, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0, 0, lat);
        set_dly(0, 4, 0, 0, 0);
        do_req(8'hF0, 64'h4000_0010, 64'h1111_2222_3333_4444, 0, 0, 0, lat);
        set_dly(2, 2, 0, 1, 0);
        do_req(8'h81, 64'h4000_0018, 64'h5555_6666_7777_8888, 0, 0, 0, lat);
        set_dly(0, 0, 0, 0, 0);
        do_req(8'h00, 64'h4000_0010, 64'h0, 0, 0, 0, lat);

        // Error responses and sticky capture
        do_req(8'h00, 64'h4000_0100, 64'h0, 1, 0, 0, lat);
`ifdef MEM_REQ_ERR_STICKY_EN
        check_eq("sticky_first", 64'(err_sticky_o), 1);
        check_eq("sticky_addr_first", err_addr_o, 64'h4000_0100);
`endif
        do_req(8'h00, 64'h4000_0208, 64'h0, 1, 0, 0, lat);
        do_req(8'h3C, 64'h4000_0020, 64'h0102_0304_0506_0708, 1, 0, 0, lat);
`ifdef MEM_REQ_ERR_STICKY_EN
        check_eq("sticky_addr_kept", err_addr_o, 64'h4000_0100);
        @(negedge clk_i); err_clr_i = 1;
        @(negedge clk_i); err_clr_i = 0; ref_sticky = 0;
        #1 check_eq("sticky_cleared", 64'(err_sticky_o), 0);
        err_clr_i = 1;
        do_req(8'h00, 64'h4000_0300, 64'h0, 1, 0, 0, lat);
        check_eq("sticky_set_wins", err_addr_o, 64'h4000_0300);
`endif

        // Back-to-back with req_i held high
        do_req(8'hFF, 64'h4000_0040, 64'hCAFE_0000_0000_0001, 0, 0, 1, lat);
        do_req(8'h00, 64'h4000_0040, 64'h0, 0, 1, 1, lat);
        do_req(8'h0F, 64'h4000_0048, 64'hCAFE_0000_0000_0002, 0, 1, 1, lat);
        do_req(8'h00, 64'h4000_0048, 64'h0, 0, 1, 0, lat);

        // Reset while waiting for the write response
        set_dly(0, 0, 0, 20, 0);
        exp_addr = 64'h4000_0080; exp_we = 8'hFF; exp_wdata = 64'h0BAD_0BAD_0BAD_0BAD; inject_err = 0;
        @(negedge clk_i);
        req_i = 1; we_i = 8'hFF; addr_i = 64'h4000_0080; wdata_i = 64'h0BAD_0BAD_0BAD_0BAD;
        #1 check_eq("rst_test_grant", 64'(gnt_o), 1);
        @(posedge clk_i); #1 req_i = 0;
        begin
            bit seen = 0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk_i); #1;
                if (axi.b_ready) begin seen = 1; break; end
            end
            check_eq("reached_wr_resp", 64'(seen), 1);
        end
        #3 rst_i = 1;
        #1;
        check_eq("async_rst_axi", {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready}, 0);
        check_eq("async_rst_outputs", {gnt_o, rvalid_o, err_o, busy_o}, 0);
        check_eq("async_rst_rdata", rdata_o, 0);
        ref_sticky = 0;
        @(negedge clk_i); @(negedge clk_i); #4 rst_i = 0;
        set_dly(0, 0, 0, 0, 0);
        do_req(8'hFF, 64'h4000_0088, 64'h7777_0000_8888_0000, 0, 0, 0, lat);
        check_eq("post_rst_latency", 64'(lat), 3);

        // Randomized traffic
        prev_hold = 0;
        for (int i = 0; i < 60; i++) begin
            logic [7:0]  we = $urandom_range(0, 1) ? 8'h00 : 8'($urandom_range(1, 255));
            logic [63:0] a  = 64'h4000_0000 + 64'($urandom_range(0, 15) << 3) + 64'($urandom_range(0, 7));
            logic [63:0] d  = {$urandom, $urandom};
            bit          e  = ($urandom_range(0, 4) == 0);
            bit          h  = (i < 59) && ($urandom_range(0, 2) == 0);
            set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
            do_req(we, a, d, e, prev_hold, h, lat);
            prev_hold = h;
        end
        req_i = 0;
        repeat (2) @(negedge clk_i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
